// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 definitions: FSM state encoding, derived cycle counts, filter helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_STOP,
    ST_ACK,
    ST_WAITIDLE
  } ps2_state_t;

  function automatic int inh_cyc(input int clkfreq_khz, input int inhibit_us);
    return clkfreq_khz * inhibit_us / 1000;
  endfunction

  function automatic int to_cyc(input int clkfreq_khz, input int timeout_ms);
    return clkfreq_khz * timeout_ms;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF synchroniser, 3-sample majority filter and clock fall detector for both PS/2 lines.
module ps2_line_sync
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clk_raw,
  input  logic dat_raw,
  output logic clk_filt,
  output logic dat_filt,
  output logic clk_fall
);

  // [0],[1] form the synchroniser; [2] extends the window to three samples
  logic [2:0] clk_q;
  logic [2:0] dat_q;
  logic       clk_filt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_q      <= '1;
      dat_q      <= '1;
      clk_filt   <= 1'b1;
      dat_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_q      <= {clk_q[1:0], clk_raw};
      dat_q      <= {dat_q[1:0], dat_raw};
      clk_filt   <= maj3(clk_q);
      dat_filt   <= maj3(dat_q);
      clk_filt_d <= clk_filt;
    end
  end

  assign clk_fall = clk_filt_d & ~clk_filt;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (request-to-send, 11-bit frame, ACK check).
// Optional frame watchdog enabled by defining PS2_TX_WATCHDOG_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLKFREQ    = 6000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_MS = 15
) (
  input  logic       clk,
  input  logic       master_reset_n,
  input  logic       ps2clk_in,
  input  logic       ps2dat_in,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe,
  input  logic [7:0] data,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int INH_CYC = inh_cyc(CLKFREQ, INHIBIT_US);
  localparam int TO_CYC  = to_cyc(CLKFREQ, TIMEOUT_MS);
  localparam int INH_W   = cnt_w(INH_CYC);
  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INH_CYC - 2);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH_CYC - 1);

  // The start bit is raised one cycle before clock release, so the hold needs two cycles
  if (INH_CYC < 2 || TO_CYC < 1) begin : g_bad_params
    $error("ps2_host_tx: inhibit must last at least 2 cycles and the timeout at least 1");
  end

  ps2_state_t       state;
  logic [8:0]       shreg;
  logic [3:0]       bit_idx;
  logic [INH_W-1:0] inh_cnt;
  logic             clk_filt;
  logic             dat_filt;
  logic             clk_fall;
  logic             wd_hit;

  ps2_line_sync u_sync (
    .clk      (clk),
    .rst_n    (master_reset_n),
    .clk_raw  (ps2clk_in),
    .dat_raw  (ps2dat_in),
    .clk_filt (clk_filt),
    .dat_filt (dat_filt),
    .clk_fall (clk_fall)
  );

`ifdef PS2_TX_WATCHDOG_EN
  localparam int WD_W = cnt_w(TO_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TO_CYC - 1);

  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk or negedge master_reset_n) begin
    if (!master_reset_n) begin
      wd_cnt <= '0;
    end else if (state == ST_IDLE) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_hit = (state != ST_IDLE) && (wd_cnt == WD_LAST);
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge master_reset_n) begin
    if (!master_reset_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      inh_cnt   <= '0;
      ps2clk_oe <= 1'b0;
      ps2dat_oe <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (wd_hit) begin
        state     <= ST_IDLE;
        ps2clk_oe <= 1'b0;
        ps2dat_oe <= 1'b0;
        busy      <= 1'b0;
        error     <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (send) begin
              shreg     <= {~^data, data};
              bit_idx   <= '0;
              inh_cnt   <= '0;
              ps2clk_oe <= 1'b1;
              busy      <= 1'b1;
              state     <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            inh_cnt <= inh_cnt + 1'b1;
            if (inh_cnt == INH_PRE) begin
              ps2dat_oe <= 1'b1;
            end
            if (inh_cnt == INH_LAST) begin
              ps2clk_oe <= 1'b0;
              state     <= ST_REQ;
            end
          end
          ST_REQ: begin
            state <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (clk_fall) begin
              ps2dat_oe <= ~shreg[bit_idx];
              if (bit_idx == 4'd8) begin
                state <= ST_STOP;
              end else begin
                bit_idx <= bit_idx + 4'd1;
              end
            end
          end
          ST_STOP: begin
            if (clk_fall) begin
              ps2dat_oe <= 1'b0;
              state     <= ST_ACK;
            end
          end
          ST_ACK: begin
            if (clk_fall) begin
              if (!dat_filt) begin
                state <= ST_WAITIDLE;
              end else begin
                error <= 1'b1;
                busy  <= 1'b0;
                state <= ST_IDLE;
              end
            end
          end
          ST_WAITIDLE: begin
            // The device must release both lines before the frame counts as finished
            if (clk_filt && dat_filt) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a 12.5 kHz PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int HALF    = 240;
  localparam int INH_EXP = 600;
  localparam int WD_EXP  = 90000;

  typedef struct {
    logic [10:0] bits;
    bit          ok;
    bit          clocked;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2clk_in;
  logic       ps2dat_in;
  logic       ps2clk_oe;
  logic       ps2dat_oe;
  logic [7:0] data = 8'h00;
  logic       send = 1'b0;
  logic       busy;
  logic       done;
  logic       error;

  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic dev_ack     = 1'b1;
  logic dev_silent  = 1'b0;
  logic dev_abort   = 1'b0;
  int   dev_lat      = -1;
  int   dev_fall_cnt = 0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_accept = 0;
  int done_cnt = 0;

  exp_t        exp_q[$];
  logic [10:0] obs_q[$];

  wire clk_line = !(ps2clk_oe || dev_clk_low);
  wire dat_line = !(ps2dat_oe || dev_dat_low);
  assign ps2clk_in = clk_line;
  assign ps2dat_in = dat_line;

  ps2_host_tx dut (
    .clk            (clk),
    .master_reset_n (rst_n),
    .ps2clk_in      (ps2clk_in),
    .ps2dat_in      (ps2dat_in),
    .ps2clk_oe      (ps2clk_oe),
    .ps2dat_oe      (ps2dat_oe),
    .data           (data),
    .send           (send),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic odd_parity(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2) == 0;
  endfunction

  function automatic exp_t model(input logic [7:0] d, input bit ok, input bit clocked);
    exp_t e;
    e.bits    = {1'b1, odd_parity(d), d, 1'b0};
    e.ok      = ok;
    e.clocked = clocked;
    return e;
  endfunction

  // Device model: answers a request-to-send with 11 clock pulses, samples on rising edges
  task automatic dev_frame();
    logic [10:0] b;
    b = '0;
    dev_lat = -1;
    repeat (60) @(negedge clk);
    b[0] = dat_line;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) begin
        repeat (HALF / 2) @(negedge clk);
        if (dev_ack) dev_dat_low = 1'b1;
        repeat (HALF / 2) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      dev_fall_cnt = k;
      for (int i = 1; i <= HALF; i++) begin
        @(negedge clk);
        if (k == 1 && dev_lat < 0 && !ps2dat_oe) dev_lat = i;
        if (dev_abort) begin
          dev_clk_low = 1'b0;
          dev_dat_low = 1'b0;
          return;
        end
      end
      dev_clk_low = 1'b0;
      if (k <= 10) b[k] = dat_line;
      if (k == 10) obs_q.push_back(b);
      if (k == 11) dev_dat_low = 1'b0;
      if (k < 11) repeat (HALF) @(negedge clk);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && clk_line && !dat_line) begin
        if (!dev_silent) dev_frame();
        while (!dat_line) @(negedge clk);
      end
    end
  end

  // Monitor: every end-of-frame pulse consumes one expectation
  initial begin
    exp_t e;
    logic [10:0] ob;
    forever begin
      @(negedge clk);
      if (rst_n && (done || error)) begin
        if (done) done_cnt++;
        check("done_error_exclusive", {31'd0, done & error}, 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_end: got done=%0b error=%0b want no pulse", done, error);
        end else begin
          e = exp_q.pop_front();
          check("outcome_done", {31'd0, done}, {31'd0, e.ok});
          check("outcome_error", {31'd0, error}, {31'd0, !e.ok});
          check("busy_at_end", {31'd0, busy}, 0);
          check("oe_released", {30'd0, ps2clk_oe, ps2dat_oe}, 0);
          if (e.clocked) begin
            if (obs_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL frame_missing: got no observed frame want %0h", e.bits);
            end else begin
              ob = obs_q.pop_front();
              check("frame_bits", {21'd0, ob}, {21'd0, e.bits});
            end
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d);
    int n;
    @(negedge clk);
    data = d;
    send = 1'b1;
    @(posedge clk);
    #1;
    t_accept = cyc;
    send = 1'b0;
    check("busy_after_send", {31'd0, busy}, 1);
    check("clk_oe_after_send", {31'd0, ps2clk_oe}, 1);
    n = 1;
    while (ps2clk_oe && n < 5000) begin
      @(posedge clk);
      #1;
      if (ps2clk_oe) n++;
    end
    check("inhibit_cycles", n, INH_EXP);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("frame_timeout", {31'd0, busy}, 0);
    repeat (5) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] d, input bit ack);
    dev_ack = ack;
    dev_fall_cnt = 0;
    exp_q.push_back(model(d, ack, 1'b1));
    send_byte(d);
    wait_idle(20000);
    dev_ack = 1'b1;
  endtask

  initial begin
    int n;
    int d0;
    logic [7:0] r;
    repeat (4) @(negedge clk);
    check("reset_outputs", {27'd0, ps2clk_oe, ps2dat_oe, busy, done, error}, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    d0 = done_cnt;
    frame(8'hED, 1'b1);
    check("edge_to_oe_latency", dev_lat, 4);
    check("done_once_ed", done_cnt - d0, 1);

    frame(8'h00, 1'b1);
    frame(8'hFF, 1'b1);
    for (int i = 0; i < 2; i++) begin
      r = 8'($urandom_range(0, 255));
      frame(r, 1'b1);
    end

    r = 8'($urandom_range(0, 255));
    frame(r, 1'b0);

    // A send pulsed mid-frame must neither start a frame nor corrupt the byte in flight
    d0 = done_cnt;
    dev_fall_cnt = 0;
    exp_q.push_back(model(8'hF4, 1'b1, 1'b1));
    send_byte(8'hF4);
    n = 0;
    while (dev_fall_cnt < 5 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("reached_bit4", {31'd0, dev_fall_cnt >= 5}, 1);
    data = 8'h12;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    data = 8'h00;
    wait_idle(20000);
    n = 0;
    repeat (3000) begin
      @(negedge clk);
      if (ps2clk_oe) n++;
    end
    check("ignored_send_no_frame", n, 0);
    check("done_once_f4", done_cnt - d0, 1);

    // Reset in the middle of the data bits
    dev_fall_cnt = 0;
    send_byte(8'hA5);
    n = 0;
    while (dev_fall_cnt < 3 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    dev_abort = 1'b1;
    rst_n = 1'b0;
    #1;
    check("reset_mid_shift", {27'd0, ps2clk_oe, ps2dat_oe, busy, done, error}, 0);
    repeat (20) @(negedge clk);
    dev_abort = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    d0 = done_cnt;
    frame(8'h5C, 1'b1);
    check("done_after_reset", done_cnt - d0, 1);

    dev_silent = 1'b1;
`ifdef PS2_TX_WATCHDOG_EN
    exp_q.push_back(model(8'h3A, 1'b0, 1'b0));
    send_byte(8'h3A);
    while (!error && (cyc - t_accept) < WD_EXP + 1000) begin
      @(posedge clk);
      #1;
    end
    check("watchdog_cycles", cyc - t_accept, WD_EXP);
    repeat (5) @(negedge clk);
`else
    send_byte(8'h3A);
    repeat (10000) @(negedge clk);
    check("silent_busy_held", {31'd0, busy}, 1);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
`endif

    check("exp_queue_drained", exp_q.size(), 0);
    check("obs_queue_drained", obs_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (400000) @(posedge clk);
    $display("FAIL global_timeout: got cycle=%0d want finish earlier", cyc);
    $fatal(1, "timeout");
  end

endmodule
